// File: rtl/vga_obj_pkg.sv
// Shared constants for the object move scheduler: direction bit
// indices, FSM state encoding, default geometry and a one-hot decoder.
package vga_obj_pkg;

    localparam int POS_W  = 10;
    localparam int CALC_W = 11;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    localparam int DEF_SCREEN_W     = 640;
    localparam int DEF_SCREEN_H     = 480;
    localparam int DEF_OBJ_SIZE     = 40;
    localparam int DEF_STEP         = 20;
    localparam int DEF_X_INIT       = 320;
    localparam int DEF_Y_INIT       = 220;
    localparam int DEF_REPEAT_DELAY = 30;
    localparam int DEF_REPEAT_RATE  = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        unique case (1'b1)
            oh[0]:   idx = 2'd0;
            oh[1]:   idx = 2'd1;
            oh[2]:   idx = 2'd2;
            oh[3]:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: searches req upward from ptr (mod 4).
// Ports: req[3:0], ptr[1:0] in; grant[3:0] one-hot and valid out.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic       valid
);

    always_comb begin
        logic [1:0] idx;
        idx   = 2'd0;
        grant = 4'b0;
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/object_move_scheduler.sv
// Moves a square object by one button request per frame with clamping
// and auto-repeat. Ports: clk, rst, push[3:0], frame_tick in;
// obj_x, obj_y, busy, drop out.
module object_move_scheduler
    import vga_obj_pkg::*;
#(
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int OBJ_SIZE     = DEF_OBJ_SIZE,
    parameter int STEP         = DEF_STEP,
    parameter int X_INIT       = DEF_X_INIT,
    parameter int Y_INIT       = DEF_Y_INIT,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       push,
    input  logic             frame_tick,
    output logic [POS_W-1:0] obj_x,
    output logic [POS_W-1:0] obj_y,
    output logic             busy,
    output logic             drop
);

    localparam int CNT_W = $clog2(REPEAT_DELAY + 1);

    localparam logic [CALC_W-1:0] X_MAX  = CALC_W'(SCREEN_W - OBJ_SIZE);
    localparam logic [CALC_W-1:0] Y_MAX  = CALC_W'(SCREEN_H - OBJ_SIZE);
    localparam logic [CALC_W-1:0] STEP_C = CALC_W'(STEP);

    state_t state, state_nxt;

    logic [3:0]        push_q;
    logic [3:0]        pending;
    logic [3:0]        grant;
    logic [3:0]        clr;
    logic [3:0]        set_vec;
    logic              gnt_valid;
    logic [1:0]        rr;
    logic [1:0]        dir;
    logic [CNT_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]  hold_nxt;
    logic              held;
    logic              fire;
    logic [CALC_W-1:0] x_cur, y_cur;
    logic [CALC_W-1:0] x_new, y_new;

    rr_arbiter4 u_arb (
        .req   (pending),
        .ptr   (rr),
        .grant (grant),
        .valid (gnt_valid)
    );

    // Hold counter reloads to DELAY-RATE on each repeat so the next
    // repeat lands RATE frames later without a modulo.
    assign held     = (push != 4'b0) && (push == push_q);
    assign hold_nxt = hold_cnt + CNT_W'(1);
    assign fire     = held && frame_tick &&
                      (hold_nxt == CNT_W'(REPEAT_DELAY));

    assign set_vec = (push & ~push_q) | (fire ? push : 4'b0);
    assign clr     = (state == ST_ARB && gnt_valid) ? grant : 4'b0;
    assign busy    = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (frame_tick && pending != 4'b0)
                          state_nxt = ST_ARB;
            ST_ARB:   state_nxt = ST_APPLY;
            ST_APPLY: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        x_cur = {1'b0, obj_x};
        y_cur = {1'b0, obj_y};
        x_new = x_cur;
        y_new = y_cur;
        unique case (dir)
            DIR_RIGHT: x_new = (x_cur + STEP_C > X_MAX) ?
                               X_MAX : x_cur + STEP_C;
            DIR_LEFT:  x_new = (x_cur >= STEP_C) ?
                               x_cur - STEP_C : '0;
            DIR_DOWN:  y_new = (y_cur + STEP_C > Y_MAX) ?
                               Y_MAX : y_cur + STEP_C;
            DIR_UP:    y_new = (y_cur >= STEP_C) ?
                               y_cur - STEP_C : '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            push_q   <= 4'b0;
            pending  <= 4'b0;
            drop     <= 1'b0;
            rr       <= 2'd0;
            dir      <= 2'd0;
            hold_cnt <= '0;
            obj_x    <= POS_W'(X_INIT);
            obj_y    <= POS_W'(Y_INIT);
        end else begin
            state   <= state_nxt;
            push_q  <= push;
            // A new set on the bit being granted wins and is not a drop.
            pending <= (pending & ~clr) | set_vec;
            drop    <= |(set_vec & pending & ~clr);
            if (!held)
                hold_cnt <= '0;
            else if (frame_tick)
                hold_cnt <= fire ?
                    CNT_W'(REPEAT_DELAY - REPEAT_RATE) : hold_nxt;
            if (state == ST_ARB && gnt_valid) begin
                dir <= onehot_idx(grant);
                rr  <= onehot_idx(grant) + 2'd1;
            end
            if (state == ST_APPLY) begin
                obj_x <= x_new[POS_W-1:0];
                obj_y <= y_new[POS_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_object_move_scheduler.sv
// Scoreboard bench for object_move_scheduler: stimulus queues expected
// positions, a negedge monitor compares when busy falls.
module tb_object_move_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] push = 4'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] obj_x, obj_y, obj_x2, obj_y2;
    logic       busy, drop, busy2, drop2;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   drop_cnt = 0;
    int   busy_run = 0;
    logic rst_edge = 1'b0;
    logic prev_busy = 1'b0;
    logic [9:0] prev_x = '0, prev_y = '0;
    int   mx, my;

    object_move_scheduler dut (
        .clk(clk), .rst(rst), .push(push), .frame_tick(frame_tick),
        .obj_x(obj_x), .obj_y(obj_y), .busy(busy), .drop(drop)
    );

    object_move_scheduler #(.X_INIT(10), .Y_INIT(10)) dut2 (
        .clk(clk), .rst(rst), .push(push), .frame_tick(frame_tick),
        .obj_x(obj_x2), .obj_y(obj_y2), .busy(busy2), .drop(drop2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic fall;
        fall = prev_busy && !busy;
        if (drop) drop_cnt++;
        if (fall && !rst_edge) begin
            if (q.size() == 0) begin
                chk("unexpected_move", 1, 0);
            end else begin
                e = q.pop_front();
                chk("obj_x", int'(obj_x), int'(e.x));
                chk("obj_y", int'(obj_y), int'(e.y));
                chk("latency", cyc - e.cyc, 3);
                chk("busy_cycles", busy_run, 2);
            end
        end
        if (!fall && !rst_edge &&
            (obj_x != prev_x || obj_y != prev_y))
            chk("stable_outside_window", 1, 0);
        busy_run  = busy ? busy_run + 1 : 0;
        prev_busy = busy;
        prev_x    = obj_x;
        prev_y    = obj_y;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        push = v;
        step();
        push = 4'b0;
        step();
    endtask

    // Expected position (mx,my) must already hold the post-move value.
    task automatic tick(input bit mv);
        exp_t e;
        frame_tick = 1'b1;
        if (mv) begin
            e.x = 10'(mx);
            e.y = 10'(my);
            e.cyc = cyc;
            q.push_back(e);
        end
        step();
        frame_tick = 1'b0;
        repeat (5) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        mx = 320;
        my = 220;
    endtask

    task automatic model_move(input int d);
        case (d)
            0: mx = (mx + 20 > 600) ? 600 : mx + 20;
            1: mx = (mx < 20) ? 0 : mx - 20;
            2: my = (my + 20 > 440) ? 440 : my + 20;
            default: my = (my < 20) ? 0 : my - 20;
        endcase
    endtask

    task automatic move(input int d);
        pulse(4'b0001 << d);
        model_move(d);
        tick(1);
    endtask

    initial begin
        int d0;
        repeat (3) step();
        rst = 1'b0;
        step();
        mx = 320;
        my = 220;
        chk("reset_x", int'(obj_x), 320);
        chk("reset_y", int'(obj_y), 220);
        chk("reset_busy", int'(busy), 0);
        chk("reset_drop", int'(drop), 0);

        move(0);
        chk("right_340", int'(obj_x), 340);

        do_reset();
        pulse(4'b0101);
        mx = 340; tick(1);
        my = 240; tick(1);
        pulse(4'b1001);
        my = 220; tick(1);
        mx = 360; tick(1);
        tick(0);

        do_reset();
        for (int i = 0; i < 12; i++) move(2);
        chk("clamp_y", int'(obj_y), 440);
        for (int i = 0; i < 15; i++) move(0);
        chk("clamp_x", int'(obj_x), 600);

        do_reset();
        move(1);
        chk("dut2_left_x", int'(obj_x2), 0);
        move(3);
        chk("dut2_up_y", int'(obj_y2), 0);
        move(1);
        chk("dut2_left_floor", int'(obj_x2), 0);

        do_reset();
        d0 = drop_cnt;
        pulse(4'b1000);
        pulse(4'b1000);
        model_move(3);
        tick(1);
        tick(0);
        chk("drop_pulses", drop_cnt - d0, 1);
        chk("drop_single_move", int'(obj_y), 200);

        do_reset();
        push = 4'b0010;
        step();
        for (int i = 1; i <= 42; i++) begin
            if (i == 1 || i == 31 || i == 37) begin
                model_move(1);
                tick(1);
            end else begin
                tick(0);
            end
        end
        chk("hold_x", int'(obj_x), 260);
        push = 4'b0;

        do_reset();
        move(0);
        pulse(4'b0001);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_x", int'(obj_x), 320);
        chk("abort_y", int'(obj_y), 220);
        chk("abort_busy", int'(busy), 0);
        mx = 320;
        my = 220;
        tick(0);
        chk("abort_no_pending", int'(obj_x), 320);

        repeat (5) step();
        chk("queue_empty", q.size(), 0);
        chk("dut2_idle", int'(busy2), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
